vector_floating_point_add_unit: RTL and testbench
=================================================

Name: vector_floating_point_add_unit

Overview:
- Vector-lane IEEE 754 floating-point add/subtract unit in the dragonfang vector execution stage.
- Decodes the operation and SEW from the execution vector supplied by the decoder.
- Computes vfadd, vfsub or vfrsub elementwise over one VLEN-bit register slice, for SEW=32 (binary32) or SEW=64 (binary64).
- Output is registered: one-cycle latency.

Parameters:
- VLEN, 64 (from riscv_v_pkg), register slice width in bits; must be a multiple of 64.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- execution_vector  input  execution_vector_t  decoded control word; this unit uses only the sew field and the fp-add operation field.
- vs2  input  VLEN  source operand 2 (vector register vs2 slice).
- vs1  input  VLEN  source operand 1 (vector register vs1 slice).
- vd  output  VLEN  result slice.
- vd_high  output  VLEN  upper result half for widening ops; unused by this unit, always 0.

Behaviour:
- Reset: while reset_n=0, vd=0 and vd_high=0, asserted immediately (asynchronous). Release takes effect at the first rising clock edge with reset_n=1.
- Latency: result for inputs sampled at edge N appears on vd after edge N. No handshake; the unit accepts a new operation every cycle.
- Operation field:
  - ADD: element = vs2 + vs1.
  - SUB: element = vs2 - vs1.
  - RSUB: element = vs1 - vs2.
  - Any other value, including no fp-add op: vd registers 0.
- sew field uses vsew encoding:
  - 3'b011 (e64): VLEN/64 binary64 lanes; lane i = bits [64i+63:64i].
  - 3'b010 (e32): VLEN/32 binary32 lanes.
  - Any other sew: vd registers 0.
- Lanes are independent and have identical semantics. Subtraction is implemented as addition with the relevant operand's sign flipped; RSUB flips the vs2 sign.
- Arithmetic: full IEEE 754-2008 addition, rounding mode round-to-nearest-even.
  - Subnormal inputs and outputs are supported (gradual underflow); no flush-to-zero.
  - Overflow yields a correctly signed infinity.
  - Exact cancellation x + (-x) yields +0.
  - (-0) + (-0) yields -0.
  - (+0) + (-0) yields +0.
- Special values:
  - Any NaN input, or inf + (-inf) after sign adjustment, yields canonical quiet NaN: 0x7FC00000 (e32), 0x7FF8000000000000 (e64).
  - inf + finite yields that inf.
  - inf + inf of the same sign yields that inf.
- No exception flags are produced. vd_high is permanently 0 after reset.
- Mid-operation reset: the in-flight result is discarded; vd=0 until the first post-reset edge.

Test Plan:
- Reset: hold reset_n=0 with arbitrary inputs -> vd=0, vd_high=0. Deassert, then ADD e64 vs2=0x3FF0000000000000, vs1=0x4000000000000000 -> next cycle vd=0x4008000000000000 (1.0+2.0=3.0).
- ADD/SUB e32, vs2={0x40400000,0x3F800000}, vs1={0x3F800000,0x3F800000}:
  - ADD -> vd={0x40800000,0x40000000}.
  - SUB -> vd={0x40000000,0x00000000} (+0 from cancellation).
- RSUB e64, vs2=0x4000000000000000, vs1=0x3FF0000000000000 -> vd=0xBFF0000000000000 (1.0-2.0).
- Specials e64:
  - ADD 0x7FF0000000000000 + 0xFFF0000000000000 -> 0x7FF8000000000000.
  - ADD with vs1=0x7FF0000000000001 (signaling NaN) -> 0x7FF8000000000000.
  - ADD 0x7FEFFFFFFFFFFFFF + itself -> 0x7FF0000000000000.
- Rounding/subnormal e64:
  - ADD 0x3FF0000000000000 + 0x3CA0000000000000 -> 0x3FF0000000000000 (tie to even).
  - ADD 0x0000000000000001 + 0x0000000000000001 -> 0x0000000000000002.
  - SUB 0x0010000000000000 - 0x000FFFFFFFFFFFFF -> 0x0000000000000001.
- Back-to-back and illegal cases:
  - Random ADD/SUB/RSUB at e32 and e64 every cycle; each result matches a reference model one cycle later.
  - sew=3'b000 -> vd=0.
  - Reset asserted mid-stream -> vd=0 immediately.

Source files
------------

// File: rtl/vector_floating_point_add_unit.sv
`default_nettype none
// ============================================================================
//  Module      : vector_floating_point_add_unit
//  Description : Vector-lane IEEE 754 add/subtract (vfadd/vfsub/vfrsub) over
//                one VLEN-bit register slice, binary32 or binary64 lanes,
//                round-to-nearest-even, one-cycle registered result.
//  Revision    : 1.0 - initial release
// ============================================================================

package riscv_v_pkg;
    localparam int VLEN = 64;

    localparam logic [2:0] SEW_E32   = 3'b010;
    localparam logic [2:0] SEW_E64   = 3'b011;

    localparam logic [2:0] FADD_ADD  = 3'd1;
    localparam logic [2:0] FADD_SUB  = 3'd2;
    localparam logic [2:0] FADD_RSUB = 3'd3;

    typedef struct packed {
        logic [2:0] sew;
        logic [2:0] fadd_op;
    } execution_vector_t;
endpackage

// One IEEE 754 adder lane; operand signs are already adjusted for subtraction.
module vfadd_lane #(
    parameter int EW = 11,
    parameter int MW = 52
) (
    input  logic [EW+MW:0] i_a,
    input  logic [EW+MW:0] i_b,
    output logic [EW+MW:0] o_y
);
    localparam int M = MW + 1;   // significand width with hidden bit
    localparam int W = M + 3;    // plus guard, round, sticky

    localparam logic [EW+MW:0] c_qnan  = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
    localparam logic [EW:0]    c_one   = {{EW{1'b0}}, 1'b1};
    localparam logic [EW:0]    c_emax  = {1'b0, {EW{1'b1}}};
    localparam logic [EW-1:0]  c_w     = EW'(W);

    logic          w_sa, w_sb;
    logic [EW-1:0] w_xa, w_xb;
    logic [MW-1:0] w_fa, w_fb;
    assign {w_sa, w_xa, w_fa} = i_a;
    assign {w_sb, w_xb, w_fb} = i_b;

    logic w_nan_a, w_nan_b, w_inf_a, w_inf_b;
    assign w_nan_a = (&w_xa) & (|w_fa);
    assign w_nan_b = (&w_xb) & (|w_fb);
    assign w_inf_a = (&w_xa) & ~(|w_fa);
    assign w_inf_b = (&w_xb) & ~(|w_fb);

    logic          w_swap, w_sl, w_ss, w_sticky, w_rup, w_sign;
    logic [EW-1:0] w_xl, w_xs, w_el, w_es, w_d;
    logic [MW-1:0] w_fl, w_fs, w_frac;
    logic [W-1:0]  w_ml, w_ms, w_sh, w_pre, w_norm;
    logic [W:0]    w_sum;
    logic [EW:0]   w_e, w_e2, w_lz, w_lim, w_shamt, w_ef;
    logic [M:0]    w_rnd;
    logic [EW+MW:0] w_fin;

    // Align the smaller magnitude, add/subtract, normalise, round to nearest even
    always_comb begin
        w_swap = {w_xb, w_fb} > {w_xa, w_fa};
        {w_sl, w_xl, w_fl} = w_swap ? i_b : i_a;
        {w_ss, w_xs, w_fs} = w_swap ? i_a : i_b;
        // Subnormals share the minimum exponent but lack the hidden bit
        w_el = (w_xl == '0) ? {{(EW-1){1'b0}}, 1'b1} : w_xl;
        w_es = (w_xs == '0) ? {{(EW-1){1'b0}}, 1'b1} : w_xs;
        w_ml = {(|w_xl), w_fl, 3'b000};
        w_ms = {(|w_xs), w_fs, 3'b000};
        w_d  = w_el - w_es;

        if (w_d >= c_w) begin
            w_sh     = '0;
            w_sticky = |w_ms;
        end else begin
            w_sh     = w_ms >> w_d;
            w_sticky = |(w_ms & ~({W{1'b1}} << w_d));
        end
        w_sh[0] = w_sh[0] | w_sticky;

        w_sum = (w_sl ^ w_ss) ? ({1'b0, w_ml} - {1'b0, w_sh})
                              : ({1'b0, w_ml} + {1'b0, w_sh});

        w_lz = (EW+1)'(W);
        for (int i = 0; i < W; i++) begin
            if (w_sum[i]) w_lz = (EW+1)'(W - 1 - i);
        end

        // Left normalisation stops at the minimum exponent (gradual underflow)
        if (w_sum[W]) begin
            w_pre   = w_sum[W:1] | {{(W-1){1'b0}}, w_sum[0]};
            w_e     = {1'b0, w_el} + c_one;
            w_lim   = '0;
            w_shamt = '0;
        end else begin
            w_pre   = w_sum[W-1:0];
            w_e     = {1'b0, w_el};
            w_lim   = w_e - c_one;
            w_shamt = (w_lz < w_lim) ? w_lz : w_lim;
        end
        w_norm = w_pre << w_shamt;
        w_e2   = w_e - w_shamt;

        w_rup = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
        w_rnd = {1'b0, w_norm[W-1:3]} + {{M{1'b0}}, w_rup};
        if (w_rnd[M]) begin
            w_ef   = w_e2 + c_one;
            w_frac = '0;
        end else begin
            w_ef   = w_rnd[M-1] ? w_e2 : '0;
            w_frac = w_rnd[MW-1:0];
        end

        // Exact cancellation gives +0; only (-0)+(-0) keeps the negative sign
        w_sign = (w_sum == '0) ? (w_sa & w_sb) : w_sl;
        if (w_ef >= c_emax) w_fin = {w_sign, {EW{1'b1}}, {MW{1'b0}}};
        else                w_fin = {w_sign, w_ef[EW-1:0], w_frac};
    end

    // Special operands override the finite datapath
    always_comb begin
        if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sa != w_sb))) o_y = c_qnan;
        else if (w_inf_a)                                                   o_y = i_a;
        else if (w_inf_b)                                                   o_y = i_b;
        else                                                                o_y = w_fin;
    end
endmodule

module vector_floating_point_add_unit #(
    parameter int VLEN = riscv_v_pkg::VLEN
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  riscv_v_pkg::execution_vector_t execution_vector,
    input  logic [VLEN-1:0]                vs2,
    input  logic [VLEN-1:0]                vs1,
    output logic [VLEN-1:0]                vd,
    output logic [VLEN-1:0]                vd_high
);
    logic            w_op_valid, w_flip_vs2, w_flip_vs1;
    logic [VLEN-1:0] w_res64, w_res32, vd_d, vd_q;

    assign w_op_valid = (execution_vector.fadd_op == riscv_v_pkg::FADD_ADD)
                     || (execution_vector.fadd_op == riscv_v_pkg::FADD_SUB)
                     || (execution_vector.fadd_op == riscv_v_pkg::FADD_RSUB);
    assign w_flip_vs2 = (execution_vector.fadd_op == riscv_v_pkg::FADD_RSUB);
    assign w_flip_vs1 = (execution_vector.fadd_op == riscv_v_pkg::FADD_SUB);

    for (genvar gi = 0; gi < VLEN / 64; gi++) begin : g_lane64
        logic [63:0] w_a, w_b;
        assign w_a = {vs2[64*gi+63] ^ w_flip_vs2, vs2[64*gi +: 63]};
        assign w_b = {vs1[64*gi+63] ^ w_flip_vs1, vs1[64*gi +: 63]};
        vfadd_lane #(.EW(11), .MW(52)) u_lane (
            .i_a (w_a),
            .i_b (w_b),
            .o_y (w_res64[64*gi +: 64])
        );
    end

    for (genvar gi = 0; gi < VLEN / 32; gi++) begin : g_lane32
        logic [31:0] w_a, w_b;
        assign w_a = {vs2[32*gi+31] ^ w_flip_vs2, vs2[32*gi +: 31]};
        assign w_b = {vs1[32*gi+31] ^ w_flip_vs1, vs1[32*gi +: 31]};
        vfadd_lane #(.EW(8), .MW(23)) u_lane (
            .i_a (w_a),
            .i_b (w_b),
            .o_y (w_res32[32*gi +: 32])
        );
    end

    // Select lane width; unsupported op or SEW produces zero
    always_comb begin
        vd_d = '0;
        if (w_op_valid) begin
            case (execution_vector.sew)
                riscv_v_pkg::SEW_E64: vd_d = w_res64;
                riscv_v_pkg::SEW_E32: vd_d = w_res32;
                default:              vd_d = '0;
            endcase
        end
    end

    // Result register, cleared asynchronously by reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) vd_q <= '0;
        else          vd_q <= vd_d;
    end

    assign vd      = vd_q;
    assign vd_high = '0;
endmodule
`default_nettype wire

// File: tb/tb_vector_floating_point_add_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_floating_point_add_unit
//  Description : Scoreboard bench for the vector FP add unit; expected values
//                come from spec constants and a real-arithmetic reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_floating_point_add_unit;
    localparam int VLEN = riscv_v_pkg::VLEN;
    localparam logic [63:0] QN64 = 64'h7FF8000000000000;
    localparam logic [31:0] QN32 = 32'h7FC00000;
    localparam logic [2:0]  OADD = riscv_v_pkg::FADD_ADD;
    localparam logic [2:0]  OSUB = riscv_v_pkg::FADD_SUB;
    localparam logic [2:0]  ORSB = riscv_v_pkg::FADD_RSUB;
    localparam logic [2:0]  E32  = riscv_v_pkg::SEW_E32;
    localparam logic [2:0]  E64  = riscv_v_pkg::SEW_E64;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    riscv_v_pkg::execution_vector_t ev;
    logic [VLEN-1:0] vs2, vs1, vd, vd_high;
    logic tb_issue = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [VLEN-1:0] exp_q[$];
    string name_q[$];

    always #5 clock = ~clock;

    vector_floating_point_add_unit #(.VLEN(VLEN)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .execution_vector (ev),
        .vs2              (vs2),
        .vs1              (vs1),
        .vd               (vd),
        .vd_high          (vd_high)
    );

    // ---------------- reference model ----------------
    function automatic bit is_nan64(input logic [63:0] x);
        return (&x[62:52]) && (|x[51:0]);
    endfunction

    function automatic bit is_nan32(input logic [31:0] x);
        return (&x[30:23]) && (|x[22:0]);
    endfunction

    function automatic real f32_to_real(input logic [31:0] x);
        real v;
        if (x[30:0] == 31'd0) return $bitstoreal({x[31], 63'd0});
        if (x[30:23] == 8'hFF) return $bitstoreal({x[31], 11'h7FF, 52'd0});
        if (x[30:23] == 8'd0) v = real'(x[22:0]) * (2.0 ** (-149.0));
        else v = real'({9'd1, x[22:0]}) * (2.0 ** (real'({24'd0, x[30:23]}) - 150.0));
        return x[31] ? -v : v;
    endfunction

    // Round a double (known to be a sum of two binary32 values) to binary32, RNE
    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] d, sig, q, rem, half;
        int e, sh;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, 23'd0};
        e   = int'({21'd0, d[62:52]}) - 1023;
        sig = {11'd0, 1'b1, d[51:0]};
        sh  = 29 + ((e < -126) ? (-126 - e) : 0);
        if (sh > 63) sh = 63;
        q    = sig >> sh;
        rem  = sig & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (e < -126) return {d[63], q[30:0]};
        if (q[24]) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e + 127 >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], 8'(e + 127), q[22:0]};
    endfunction

    function automatic real apply_op(input logic [2:0] op, input real a2, input real a1);
        case (op)
            OADD:    return a2 + a1;
            OSUB:    return a2 - a1;
            default: return a1 - a2;
        endcase
    endfunction

    function automatic logic [63:0] ref64(input logic [2:0] op, input logic [63:0] x2, input logic [63:0] x1);
        logic [63:0] rb;
        if (is_nan64(x2) || is_nan64(x1)) return QN64;
        rb = $realtobits(apply_op(op, $bitstoreal(x2), $bitstoreal(x1)));
        if (is_nan64(rb)) return QN64;
        return rb;
    endfunction

    function automatic logic [31:0] ref32(input logic [2:0] op, input logic [31:0] x2, input logic [31:0] x1);
        logic [63:0] rb;
        if (is_nan32(x2) || is_nan32(x1)) return QN32;
        rb = $realtobits(apply_op(op, f32_to_real(x2), f32_to_real(x1)));
        if (is_nan64(rb)) return QN32;
        return real_to_f32($bitstoreal(rb));
    endfunction

    function automatic logic [VLEN-1:0] model(input logic [2:0] op, input logic [2:0] sew,
                                              input logic [VLEN-1:0] a2, input logic [VLEN-1:0] a1);
        logic [VLEN-1:0] res;
        res = '0;
        if (op != OADD && op != OSUB && op != ORSB) return res;
        if (sew == E64) begin
            for (int i = 0; i < VLEN / 64; i++) res[64*i +: 64] = ref64(op, a2[64*i +: 64], a1[64*i +: 64]);
        end else if (sew == E32) begin
            for (int i = 0; i < VLEN / 32; i++) res[32*i +: 32] = ref32(op, a2[32*i +: 32], a1[32*i +: 32]);
        end
        return res;
    endfunction

    // ---------------- operand generators ----------------
    function automatic logic [63:0] gen64(input logic [10:0] base);
        logic [63:0] x;
        logic [10:0] e;
        int m;
        m = int'($urandom_range(0, 9));
        x = {$urandom, $urandom};
        if (m == 0) return x;
        if (m == 1) begin
            case ($urandom_range(0, 7))
                0:       return 64'h0000000000000000;
                1:       return 64'h8000000000000000;
                2:       return 64'h7FF0000000000000;
                3:       return 64'hFFF0000000000000;
                4:       return 64'h7FF8000000000000;
                5:       return 64'h7FF0000000000001;
                6:       return 64'h0000000000000001;
                default: return 64'h7FEFFFFFFFFFFFFF;
            endcase
        end
        e = (base > 11'd2) ? base - 11'($urandom_range(0, 2)) : base;
        return {x[63], e, x[51:0]};
    endfunction

    function automatic logic [31:0] gen32(input logic [7:0] base);
        logic [31:0] x;
        logic [7:0] e;
        int m;
        m = int'($urandom_range(0, 9));
        x = $urandom;
        if (m == 0) return x;
        if (m == 1) begin
            case ($urandom_range(0, 7))
                0:       return 32'h00000000;
                1:       return 32'h80000000;
                2:       return 32'h7F800000;
                3:       return 32'hFF800000;
                4:       return 32'h7FC00000;
                5:       return 32'h7F800001;
                6:       return 32'h00000001;
                default: return 32'h7F7FFFFF;
            endcase
        end
        e = (base > 8'd2) ? base - 8'($urandom_range(0, 2)) : base;
        return {x[31], e, x[22:0]};
    endfunction

    // ---------------- stimulus / scoreboard ----------------
    task automatic issue(input logic [2:0] op, input logic [2:0] sew, input logic [VLEN-1:0] a2,
                         input logic [VLEN-1:0] a1, input logic [VLEN-1:0] expv, input string name);
        @(negedge clock);
        ev.fadd_op = op;
        ev.sew     = sew;
        vs2        = a2;
        vs1        = a1;
        tb_issue   = 1'b1;
        exp_q.push_back(expv);
        name_q.push_back(name);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (vd !== '0 || vd_high !== '0) begin
            failures++;
            $display("FAIL %s: vd=%h vd_high=%h expected both 0", name, vd, vd_high);
        end
    endtask

    // Monitor: one registered result per issued operation, one cycle later
    always @(posedge clock) begin : mon
        logic [VLEN-1:0] e;
        string n;
        if (tb_issue) begin
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow: vd=%h with no expected entry", vd);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (vd !== e || vd_high !== '0) begin
                    failures++;
                    $display("FAIL %s: vd=%h vd_high=%h expected vd=%h vd_high=0", n, vd, vd_high, e);
                end
            end
        end
    end

    initial begin
        logic [2:0] op, sew;
        logic [VLEN-1:0] a2, a1;
        logic [10:0] b11;
        logic [7:0] b8;

        ev.fadd_op = OADD;
        ev.sew     = E64;
        vs2        = {(VLEN/32){$urandom}};
        vs1        = {(VLEN/32){$urandom}};
        #2 reset_n = 1'b0;
        #1 check_zero("reset_async");
        repeat (2) @(posedge clock);
        #1 check_zero("reset_held");
        @(negedge clock) reset_n = 1'b1;

        // Directed vectors
        issue(OADD, E64, {(VLEN/64){64'h3FF0000000000000}}, {(VLEN/64){64'h4000000000000000}},
              {(VLEN/64){64'h4008000000000000}}, "add64_1p2");
        issue(OADD, E32, {(VLEN/64){64'h40400000_3F800000}}, {(VLEN/64){64'h3F800000_3F800000}},
              {(VLEN/64){64'h40800000_40000000}}, "add32");
        issue(OSUB, E32, {(VLEN/64){64'h40400000_3F800000}}, {(VLEN/64){64'h3F800000_3F800000}},
              {(VLEN/64){64'h40000000_00000000}}, "sub32_cancel");
        issue(ORSB, E64, {(VLEN/64){64'h4000000000000000}}, {(VLEN/64){64'h3FF0000000000000}},
              {(VLEN/64){64'hBFF0000000000000}}, "rsub64");
        issue(OADD, E64, {(VLEN/64){64'h7FF0000000000000}}, {(VLEN/64){64'hFFF0000000000000}},
              {(VLEN/64){QN64}}, "inf_minus_inf");
        issue(OADD, E64, {(VLEN/64){64'h3FF0000000000000}}, {(VLEN/64){64'h7FF0000000000001}},
              {(VLEN/64){QN64}}, "snan64");
        issue(OADD, E64, {(VLEN/64){64'h7FEFFFFFFFFFFFFF}}, {(VLEN/64){64'h7FEFFFFFFFFFFFFF}},
              {(VLEN/64){64'h7FF0000000000000}}, "overflow64");
        issue(OADD, E64, {(VLEN/64){64'h3FF0000000000000}}, {(VLEN/64){64'h3CA0000000000000}},
              {(VLEN/64){64'h3FF0000000000000}}, "tie_even");
        issue(OADD, E64, {(VLEN/64){64'h0000000000000001}}, {(VLEN/64){64'h0000000000000001}},
              {(VLEN/64){64'h0000000000000002}}, "subnorm_add");
        issue(OSUB, E64, {(VLEN/64){64'h0010000000000000}}, {(VLEN/64){64'h000FFFFFFFFFFFFF}},
              {(VLEN/64){64'h0000000000000001}}, "subnorm_sub");
        issue(OADD, E64, {(VLEN/64){64'h8000000000000000}}, {(VLEN/64){64'h8000000000000000}},
              {(VLEN/64){64'h8000000000000000}}, "negzero_sum");
        issue(OADD, E64, {(VLEN/64){64'h0000000000000000}}, {(VLEN/64){64'h8000000000000000}},
              {(VLEN/64){64'h0000000000000000}}, "mixed_zero_sum");
        issue(OADD, E32, {(VLEN/64){64'h7F800000_7F7FFFFF}}, {(VLEN/64){64'hFF800000_7F7FFFFF}},
              {(VLEN/64){64'h7FC00000_7F800000}}, "specials32");
        issue(OADD, 3'b000, {(VLEN/64){64'h3FF0000000000000}}, {(VLEN/64){64'h3FF0000000000000}},
              '0, "sew_illegal");
        issue(3'd5, E64, {(VLEN/64){64'h3FF0000000000000}}, {(VLEN/64){64'h3FF0000000000000}},
              '0, "op_illegal");

        // Randomised back-to-back traffic
        for (int it = 0; it < 400; it++) begin
            op  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(1, 3));
            sew = ($urandom_range(0, 9) == 0) ? 3'b000 : (($urandom_range(0, 1) == 0) ? E32 : E64);
            b11 = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2)) : 11'($urandom_range(1, 2046));
            b8  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(1, 254));
            for (int i = 0; i < VLEN / 64; i++) begin
                a2[64*i +: 64] = gen64(b11);
                a1[64*i +: 64] = gen64(b11);
            end
            if (sew == E32) begin
                for (int i = 0; i < VLEN / 32; i++) begin
                    a2[32*i +: 32] = gen32(b8);
                    a1[32*i +: 32] = gen32(b8);
                end
            end
            issue(op, sew, a2, a1, model(op, sew, a2, a1), "random");
        end

        // Reset in the middle of the stream
        issue(OADD, E64, {(VLEN/64){64'h3FF0000000000000}}, {(VLEN/64){64'h4000000000000000}},
              {(VLEN/64){64'h4008000000000000}}, "pre_reset");
        @(posedge clock);
        #3;
        tb_issue = 1'b0;
        reset_n  = 1'b0;
        #1 check_zero("midstream_reset");
        @(posedge clock);
        #1 check_zero("midstream_reset_held");
        @(negedge clock) reset_n = 1'b1;
        issue(ORSB, E64, {(VLEN/64){64'h4000000000000000}}, {(VLEN/64){64'h3FF0000000000000}},
              {(VLEN/64){64'hBFF0000000000000}}, "post_reset");
        @(negedge clock) tb_issue = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
